wptr_full_ctrl: RTL and testbench
=================================

WPTR_FULL_CTRL -- requirements
Module: wptr_full_ctrl

Interface
REQ-001 SHALL have parameter addr_size, default 4: FIFO depth is 2**addr_size, and addr_size SHALL be at least 2.
REQ-002 SHALL have parameter afull_margin, default 2: wafull threshold is depth minus afull_margin, legal range 1..depth-1.
REQ-003 SHALL have port wclk, input, 1 bit: write-domain clock; all state changes on its rising edge.
REQ-004 SHALL have port wrst, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port winc, input, 1 bit: write request.
REQ-006 SHALL have port r_sync, input, addr_size+1 bits: Gray-coded read pointer, already synchronized into wclk.
REQ-007 SHALL have port wfull, output reg, 1 bit: FIFO full.
REQ-008 SHALL have port wafull, output reg, 1 bit: FIFO almost full.
REQ-009 SHALL have port wptr, output reg, addr_size+1 bits: Gray-coded write pointer, sent to the read-domain synchronizer.
REQ-010 SHALL have port waddr, output, addr_size bits: write address to the RAM.
REQ-011 SHALL have port wlevel, output reg, addr_size+1 bits: fill level as seen from the write side.
REQ-012 SHALL have port wovf, output reg, 1 bit: sticky overflow flag; present only with WOVF_FLAG_EN.

Function
REQ-013 SHALL hold internal binary pointer wbin (addr_size+1 bits); waddr = wbin[addr_size-1:0], combinational.
REQ-014 SHALL compute wbnext = wbin + (winc & ~wfull), wrapping modulo 2**(addr_size+1); wgnext = (wbnext>>1) ^ wbnext.
REQ-015 SHALL register wbin<=wbnext and wptr<=wgnext every cycle, so wptr changes by exactly one bit per accepted write.
REQ-016 SHALL register wfull <= (wgnext == {~r_sync[addr_size:addr_size-1], r_sync[addr_size-2:0]}), i.e. one-cycle latency from the accepted write or the r_sync change.
REQ-017 SHALL convert r_sync to binary rbin_s combinationally, then register wlevel <= wbnext - rbin_s (modulo 2**(addr_size+1)).
REQ-018 SHALL register wafull <= (wbnext - rbin_s) >= depth - afull_margin, with the same latency as wfull.
REQ-019 SHALL ignore winc while wfull=1: wbin, wptr and waddr are unchanged.
REQ-020 SHALL treat a simultaneous accepted write and r_sync advance as net level change zero: wfull, wafull and wlevel follow the formulas above with no priority logic.
REQ-021 SHALL guarantee wfull=1 exactly when wlevel==depth, and wafull=1 whenever wfull=1.
REQ-022 SHALL tolerate r_sync values lagging the true read pointer; the resulting flags are pessimistic and never late.

Reset
REQ-023 SHALL, on wrst=0, immediately clear wbin, wptr, wlevel, wfull, wafull (and wovf) to 0, independent of wclk.
REQ-024 SHALL, on reset assertion mid-operation, discard in-flight writes; the first write after release uses waddr=0.
REQ-025 SHALL release reset on a wclk edge; the integration is responsible for synchronizing the reset deassertion.

Configuration
REQ-026 SHALL, with macro WOVF_FLAG_EN defined, provide port wovf, set to 1 on any cycle with winc=1 and wfull=1, and clear it only by reset.
REQ-027 SHALL, without WOVF_FLAG_EN, omit port wovf and its register; all other behaviour is identical.

Structure
REQ-028 SHALL place shared constants in the common FIFO package: default addr_size, default afull_margin, and the bin-to-Gray and Gray-to-bin functions.
REQ-029 SHALL use one sub-module, gray2bin (parameter width), for the r_sync conversion; bin-to-Gray stays inline.

Verification (addr_size=4, afull_margin=2, r_sync held 0 unless stated)
REQ-030 SHALL check async reset mid-burst: wrst low between clock edges -> wfull=0, wafull=0, wptr=0, wlevel=0, waddr=0 immediately.
REQ-031 SHALL check filling: 16 consecutive writes -> wlevel=14 and wafull=1 after write 14; wfull=1, wlevel=16 and wptr=5'b11000 after write 16.
REQ-032 SHALL check write-while-full: winc held 3 cycles while full -> wptr, waddr and wlevel unchanged; wovf=1 with WOVF_FLAG_EN, port absent without it.
REQ-033 SHALL check read release: with the FIFO full, r_sync=5'b00001 -> next cycle wfull=0, wlevel=15, wafull=1.
REQ-034 SHALL check steady state: writes every cycle with r_sync tracking gray(wbin-4) -> wlevel constant at 4, wptr wraps from 5'b10000 to 5'b00000 after 32 writes, never full.
REQ-035 SHALL check simultaneous events: at wlevel=15, a write plus an r_sync advance in the same cycle -> wlevel stays 15 and wfull stays 0.

Source files
------------

// File: rtl/wptr_full_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// wptr_full_ctrl_pkg
// Shared constants and pointer-code helpers for the asynchronous FIFO
// write-side logic.
//   ADDR_SIZE_DEFAULT    : default address width (FIFO depth = 2**addr_size)
//   AFULL_MARGIN_DEFAULT : default distance from full at which wafull rises
//   bin_to_gray()        : binary -> reflected Gray code (up to 32 bits)
//   gray_to_bin()        : reflected Gray code -> binary (up to 32 bits)
// The helpers work on 32-bit zero-extended values. Narrower pointers convert
// correctly because leading zeros do not change either code.
// -----------------------------------------------------------------------------
package wptr_full_ctrl_pkg;

  localparam int ADDR_SIZE_DEFAULT    = 4;
  localparam int AFULL_MARGIN_DEFAULT = 2;

  function automatic logic [31:0] bin_to_gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [31:0] gray_to_bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/wptr_full_ctrl_gray2bin.sv
// -----------------------------------------------------------------------------
// gray2bin
// Purely combinational Gray-to-binary converter.
//   Parameter width : code width in bits
//   gray_i [width]  : Gray-coded input
//   bin_o  [width]  : binary equivalent
// -----------------------------------------------------------------------------
module gray2bin #(
  parameter int width = 5
) (
  input  logic [width-1:0] gray_i,
  output logic [width-1:0] bin_o
);

  // Each binary bit is the XOR of its own Gray bit and every more-significant
  // Gray bit.
  for (genvar gi = 0; gi < width; gi++) begin : g_bit
    assign bin_o[gi] = ^gray_i[width-1:gi];
  end

endmodule

// File: rtl/wptr_full_ctrl.sv
// -----------------------------------------------------------------------------
// wptr_full_ctrl
// Write-domain pointer and full/almost-full logic of an asynchronous FIFO.
// Optional feature macro: WOVF_FLAG_EN (adds the sticky overflow flag wovf).
//
// Parameters
//   addr_size    : address width, FIFO depth = 2**addr_size (>= 2)
//   afull_margin : wafull asserts at fill level >= depth - afull_margin
// Ports
//   wclk   in  : write clock, all state changes on its rising edge
//   wrst   in  : asynchronous active-low reset
//   winc   in  : write request, ignored while wfull is high
//   r_sync in  : Gray read pointer, already synchronized into wclk
//   wfull  out : FIFO full (registered)
//   wafull out : FIFO almost full (registered)
//   wptr   out : Gray write pointer for the read-domain synchronizer
//   waddr  out : RAM write address (low bits of the binary pointer)
//   wlevel out : fill level as seen from the write side (registered)
//   wovf   out : sticky overflow flag (only with WOVF_FLAG_EN)
// -----------------------------------------------------------------------------
module wptr_full_ctrl
  import wptr_full_ctrl_pkg::*;
#(
  parameter int addr_size    = ADDR_SIZE_DEFAULT,
  parameter int afull_margin = AFULL_MARGIN_DEFAULT
) (
  input  logic                 wclk,
  input  logic                 wrst,
  input  logic                 winc,
  input  logic [addr_size:0]   r_sync,
  output logic                 wfull,
  output logic                 wafull,
  output logic [addr_size:0]   wptr,
  output logic [addr_size-1:0] waddr,
  output logic [addr_size:0]   wlevel
`ifdef WOVF_FLAG_EN
  ,
  output logic                 wovf
`endif
);

  localparam int DEPTH = 1 << addr_size;
  localparam logic [addr_size:0] AFULL_THRESH = (addr_size+1)'(DEPTH - afull_margin);

  if (addr_size < 2) begin : g_bad_addr_size
    $error("wptr_full_ctrl: addr_size must be at least 2");
  end
  if (afull_margin < 1 || afull_margin > DEPTH - 1) begin : g_bad_margin
    $error("wptr_full_ctrl: afull_margin must be in 1..depth-1");
  end

  logic [addr_size:0] wbin_q,   wbin_d;
  logic [addr_size:0] wptr_q,   wptr_d;
  logic [addr_size:0] wlevel_q, wlevel_d;
  logic               wfull_q,  wfull_d;
  logic               wafull_q, wafull_d;
  logic [addr_size:0] rbin_s;
  logic [addr_size:0] full_code;
  logic               wr_accept;

  gray2bin #(
    .width (addr_size + 1)
  ) u_rsync_g2b (
    .gray_i (r_sync),
    .bin_o  (rbin_s)
  );

  assign wr_accept = winc & ~wfull_q;
  assign wbin_d    = wbin_q + {{addr_size{1'b0}}, wr_accept};
  assign wptr_d    = (wbin_d >> 1) ^ wbin_d;

  // Full when the write pointer has lapped the read pointer once: in Gray code
  // that is the read pointer with its two MSBs inverted and the rest equal.
  assign full_code = {~r_sync[addr_size:addr_size-1], r_sync[addr_size-2:0]};
  assign wfull_d   = (wptr_d == full_code);

  // Level uses the post-write pointer, so a write and a read in the same cycle
  // cancel without any priority logic. Modulo arithmetic handles wrap.
  assign wlevel_d  = wbin_d - rbin_s;
  assign wafull_d  = (wlevel_d >= AFULL_THRESH);

  always_ff @(posedge wclk or negedge wrst) begin
    if (!wrst) begin
      wbin_q   <= '0;
      wptr_q   <= '0;
      wlevel_q <= '0;
      wfull_q  <= 1'b0;
      wafull_q <= 1'b0;
    end else begin
      wbin_q   <= wbin_d;
      wptr_q   <= wptr_d;
      wlevel_q <= wlevel_d;
      wfull_q  <= wfull_d;
      wafull_q <= wafull_d;
    end
  end

  assign wfull  = wfull_q;
  assign wafull = wafull_q;
  assign wptr   = wptr_q;
  assign wlevel = wlevel_q;
  assign waddr  = wbin_q[addr_size-1:0];

`ifdef WOVF_FLAG_EN
  logic wovf_q, wovf_d;

  // Sticky: any write attempt against a full FIFO sets it until reset.
  assign wovf_d = wovf_q | (winc & wfull_q);

  always_ff @(posedge wclk or negedge wrst) begin
    if (!wrst) begin
      wovf_q <= 1'b0;
    end else begin
      wovf_q <= wovf_d;
    end
  end

  assign wovf = wovf_q;
`endif

endmodule

// File: tb/tb_wptr_full_ctrl.sv
// -----------------------------------------------------------------------------
// tb_wptr_full_ctrl
// Directed self-checking bench for wptr_full_ctrl (addr_size=4, margin=2).
// Build with WOVF_FLAG_EN defined to also exercise the overflow flag.
// -----------------------------------------------------------------------------
module tb_wptr_full_ctrl;

  localparam int AS = 4;

  logic          wclk = 1'b0;
  logic          wrst = 1'b0;
  logic          winc = 1'b0;
  logic [AS:0]   r_sync = '0;
  logic          wfull;
  logic          wafull;
  logic [AS:0]   wptr;
  logic [AS-1:0] waddr;
  logic [AS:0]   wlevel;
`ifdef WOVF_FLAG_EN
  logic          wovf;
`endif

  int errors = 0;
  int checks = 0;

  wptr_full_ctrl #(
    .addr_size    (AS),
    .afull_margin (2)
  ) dut (
    .wclk   (wclk),
    .wrst   (wrst),
    .winc   (winc),
    .r_sync (r_sync),
    .wfull  (wfull),
    .wafull (wafull),
    .wptr   (wptr),
    .waddr  (waddr),
    .wlevel (wlevel)
`ifdef WOVF_FLAG_EN
    ,
    .wovf   (wovf)
`endif
  );

  always #5 wclk = ~wclk;

  function automatic logic [AS:0] gray(input logic [AS:0] b);
    return (b >> 1) ^ b;
  endfunction

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge wclk);
    #1;
  endtask

  task automatic test_reset();
    wrst = 1'b0; winc = 1'b0; r_sync = '0;
    tick(); tick();
    checks++; if (wfull !== 1'b0) begin errors++; $display("FAIL reset_wfull got %b expected 0", wfull); end
    checks++; if (wafull !== 1'b0) begin errors++; $display("FAIL reset_wafull got %b expected 0", wafull); end
    checks++; if (wptr !== 5'b00000) begin errors++; $display("FAIL reset_wptr got %b expected 00000", wptr); end
    checks++; if (wlevel !== 5'd0) begin errors++; $display("FAIL reset_wlevel got %0d expected 0", wlevel); end
    checks++; if (waddr !== 4'd0) begin errors++; $display("FAIL reset_waddr got %0d expected 0", waddr); end
`ifdef WOVF_FLAG_EN
    checks++; if (wovf !== 1'b0) begin errors++; $display("FAIL reset_wovf got %b expected 0", wovf); end
`endif
    wrst = 1'b1;
    tick();
    $display("reset released: wptr=%b wlevel=%0d", wptr, wlevel);
  endtask

  task automatic test_fill();
    logic [AS:0] n;
    winc = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      tick();
      n = 5'(i);
      $display("fill write %0d: wptr=%b waddr=%0d wlevel=%0d wafull=%b wfull=%b", i, wptr, waddr, wlevel, wafull, wfull);
      checks++; if (wlevel !== n) begin errors++; $display("FAIL fill_wlevel write %0d got %0d expected %0d", i, wlevel, n); end
      checks++; if (wptr !== gray(n)) begin errors++; $display("FAIL fill_wptr write %0d got %b expected %b", i, wptr, gray(n)); end
      checks++; if (waddr !== n[AS-1:0]) begin errors++; $display("FAIL fill_waddr write %0d got %0d expected %0d", i, waddr, n[AS-1:0]); end
      checks++; if (wafull !== (i >= 14)) begin errors++; $display("FAIL fill_wafull write %0d got %b expected %b", i, wafull, (i >= 14)); end
      checks++; if (wfull !== (i == 16)) begin errors++; $display("FAIL fill_wfull write %0d got %b expected %b", i, wfull, (i == 16)); end
    end
    checks++; if (wptr !== 5'b11000) begin errors++; $display("FAIL fill_final_wptr got %b expected 11000", wptr); end
`ifdef WOVF_FLAG_EN
    checks++; if (wovf !== 1'b0) begin errors++; $display("FAIL fill_wovf got %b expected 0", wovf); end
`endif
  endtask

  task automatic test_write_while_full();
    winc = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      $display("write while full %0d: wptr=%b waddr=%0d wlevel=%0d", i, wptr, waddr, wlevel);
      checks++; if (wptr !== 5'b11000) begin errors++; $display("FAIL wwf_wptr cycle %0d got %b expected 11000", i, wptr); end
      checks++; if (waddr !== 4'd0) begin errors++; $display("FAIL wwf_waddr cycle %0d got %0d expected 0", i, waddr); end
      checks++; if (wlevel !== 5'd16) begin errors++; $display("FAIL wwf_wlevel cycle %0d got %0d expected 16", i, wlevel); end
      checks++; if (wfull !== 1'b1) begin errors++; $display("FAIL wwf_wfull cycle %0d got %b expected 1", i, wfull); end
    end
`ifdef WOVF_FLAG_EN
    checks++; if (wovf !== 1'b1) begin errors++; $display("FAIL wwf_wovf got %b expected 1", wovf); end
`endif
    winc = 1'b0;
  endtask

  task automatic test_read_release();
    r_sync = 5'b00001;
    tick();
    $display("read release: wfull=%b wafull=%b wlevel=%0d", wfull, wafull, wlevel);
    checks++; if (wfull !== 1'b0) begin errors++; $display("FAIL release_wfull got %b expected 0", wfull); end
    checks++; if (wlevel !== 5'd15) begin errors++; $display("FAIL release_wlevel got %0d expected 15", wlevel); end
    checks++; if (wafull !== 1'b1) begin errors++; $display("FAIL release_wafull got %b expected 1", wafull); end
`ifdef WOVF_FLAG_EN
    checks++; if (wovf !== 1'b1) begin errors++; $display("FAIL release_wovf_sticky got %b expected 1", wovf); end
`endif
  endtask

  task automatic test_simultaneous();
    // Level 15 with rbin=1: one write and one read pointer step together.
    winc = 1'b1;
    r_sync = 5'b00011;
    tick();
    winc = 1'b0;
    $display("simultaneous: wptr=%b wlevel=%0d wfull=%b", wptr, wlevel, wfull);
    checks++; if (wlevel !== 5'd15) begin errors++; $display("FAIL simul_wlevel got %0d expected 15", wlevel); end
    checks++; if (wfull !== 1'b0) begin errors++; $display("FAIL simul_wfull got %b expected 0", wfull); end
    checks++; if (wptr !== 5'b11001) begin errors++; $display("FAIL simul_wptr got %b expected 11001", wptr); end
    checks++; if (wafull !== 1'b1) begin errors++; $display("FAIL simul_wafull got %b expected 1", wafull); end
  endtask

  task automatic test_async_reset();
    r_sync = 5'b00011;
    winc = 1'b1;
    tick();
    tick();
    // Assert reset between clock edges; outputs must clear without a clock.
    #3;
    wrst = 1'b0;
    #1;
    $display("async reset mid-burst: wptr=%b wlevel=%0d wfull=%b", wptr, wlevel, wfull);
    checks++; if (wfull !== 1'b0) begin errors++; $display("FAIL areset_wfull got %b expected 0", wfull); end
    checks++; if (wafull !== 1'b0) begin errors++; $display("FAIL areset_wafull got %b expected 0", wafull); end
    checks++; if (wptr !== 5'b00000) begin errors++; $display("FAIL areset_wptr got %b expected 00000", wptr); end
    checks++; if (wlevel !== 5'd0) begin errors++; $display("FAIL areset_wlevel got %0d expected 0", wlevel); end
    checks++; if (waddr !== 4'd0) begin errors++; $display("FAIL areset_waddr got %0d expected 0", waddr); end
`ifdef WOVF_FLAG_EN
    checks++; if (wovf !== 1'b0) begin errors++; $display("FAIL areset_wovf got %b expected 0", wovf); end
`endif
    winc = 1'b0;
    r_sync = '0;
    tick();
    wrst = 1'b1;
    winc = 1'b1;
    tick();
    winc = 1'b0;
    $display("first write after reset: wptr=%b waddr=%0d wlevel=%0d", wptr, waddr, wlevel);
    checks++; if (wptr !== 5'b00001) begin errors++; $display("FAIL areset_first_wptr got %b expected 00001", wptr); end
    checks++; if (waddr !== 4'd1) begin errors++; $display("FAIL areset_first_waddr got %0d expected 1", waddr); end
    checks++; if (wlevel !== 5'd1) begin errors++; $display("FAIL areset_first_wlevel got %0d expected 1", wlevel); end
  endtask

  task automatic test_back_to_back();
    logic [AS:0] k;
    // Fresh start so the pointer wrap lands on write 32.
    wrst = 1'b0; winc = 1'b0; r_sync = '0;
    tick();
    wrst = 1'b1;
    winc = 1'b1;
    for (int i = 1; i <= 36; i++) begin
      tick();
      k = 5'(i);
      // Reader trails four entries behind the pointer the next edge produces.
      if (i >= 4) r_sync = gray(5'(i - 3));
      $display("steady write %0d: wptr=%b wlevel=%0d wfull=%b", i, wptr, wlevel, wfull);
      checks++; if (wptr !== gray(k)) begin errors++; $display("FAIL steady_wptr write %0d got %b expected %b", i, wptr, gray(k)); end
      checks++; if (wfull !== 1'b0) begin errors++; $display("FAIL steady_wfull write %0d got %b expected 0", i, wfull); end
      checks++; if (wafull !== 1'b0) begin errors++; $display("FAIL steady_wafull write %0d got %b expected 0", i, wafull); end
      if (i >= 4) begin
        checks++; if (wlevel !== 5'd4) begin errors++; $display("FAIL steady_wlevel write %0d got %0d expected 4", i, wlevel); end
      end
      if (i == 31) begin
        checks++; if (wptr !== 5'b10000) begin errors++; $display("FAIL steady_wptr31 got %b expected 10000", wptr); end
      end
      if (i == 32) begin
        checks++; if (wptr !== 5'b00000) begin errors++; $display("FAIL steady_wrap got %b expected 00000", wptr); end
      end
    end
    winc = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fill();
    test_write_while_full();
    test_read_release();
    test_simultaneous();
    test_async_reset();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
